note_player: RTL
================

# note_player

Sequencer stage directly upstream of `sine_reader`. It accepts one note (pitch code plus duration in beats) from the song controller and converts the pitch to a 20-bit phase step through a frequency ROM. It gates the codec's sample requests into `generate_next` pulses for `sine_reader` and counts beats until the note expires. It also re-registers the returned samples for `wave_capture` and the codec, forcing silence on rests.

## Interface
- `NOTE_W`, 6: pitch code width; code 0 is a rest, codes 1..63 are semitones with 1 = A1.
- `DUR_W`, 6: duration width, in beats.
- `STEP_W`, 20: phase step width, {10-bit integer, 10-bit fraction}.
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `play_enable` in 1: 0 pauses beat counting and sample generation.
- `load_new_note` in 1: one-cycle strobe that loads `note_to_load` and `duration_to_load`.
- `note_to_load` in `NOTE_W`: pitch code.
- `duration_to_load` in `DUR_W`: length in beats.
- `beat` in 1: one-cycle tick, 48 per second.
- `generate_next_sample` in 1: codec sample request pulse.
- `sample_in` in 16: sample from `sine_reader`.
- `sample_ready_in` in 1: `sine_reader` sample strobe.
- `step_size` out `STEP_W`: phase increment to `sine_reader`.
- `generate_next` out 1: request to `sine_reader`.
- `sample_out` out 16: sample to `wave_capture` and the codec.
- `new_sample_ready` out 1: strobe accompanying `sample_out`.
- `done_with_note` out 1: one-cycle pulse when the note expires.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- States: IDLE, LOAD, PLAYING.
- **IDLE**
  - `load_new_note=1`: latch the note and duration, present the note to the ROM, go to LOAD.
  - Otherwise stay in IDLE.
- **LOAD**
  - Register the ROM output into `step_size`.
  - Set `remaining` = max(duration, 1), so duration 0 behaves as 1.
  - Always go to PLAYING next cycle.
- **PLAYING**
  - On `beat & play_enable`, `remaining` decrements.
  - When `beat & play_enable & remaining==1`: pulse `done_with_note`, go to IDLE.
  - `step_size` holds its value until the next LOAD.
- `load_new_note` is ignored in LOAD and PLAYING.
  - A load in the same cycle as `done_with_note` is ignored; the controller reloads on a following cycle.
- `beat` in IDLE or LOAD is ignored.
- `generate_next` = `generate_next_sample & play_enable & (state==PLAYING)`, combinational.
- Sample path: on `sample_ready_in`:
  - `sample_out` ← `sample_in`, or 0 if the latched note is 0.
  - `new_sample_ready` pulses one cycle later.
- `sample_ready_in` is forwarded in any state, so a sample requested before expiry still propagates.
- Paused (`play_enable=0`): `remaining` and `step_size` are frozen and no new requests are issued.
- Frequency ROM:
  - 64 × `STEP_W`, registered output.
  - Entry 0 = 0.
  - Entry 50 (A#5) = {10'd159, 10'd62}.
  - Entry 63 (B6) = {10'd337, 10'd942}.
  - Remaining entries follow equal temperament, computed offline.

## Timing
- Reset (async, any state): state=IDLE; all of the following are 0:
  - `step_size`, `sample_out`, `remaining`
  - `generate_next`, `new_sample_ready`, `done_with_note`, `busy`
- Reset asserted mid-note aborts the note with no `done_with_note` pulse.
- Load at cycle N:
  - LOAD at N+1.
  - `step_size` valid and state PLAYING at N+2.
  - `busy` high from N+1.
- Duration D ≥ 1:
  - `done_with_note` asserts in the cycle of the D-th enabled beat seen in PLAYING.
  - State is IDLE the following cycle.
- `sample_out` / `new_sample_ready` latency: exactly 1 cycle after `sample_ready_in`.
- `generate_next` latency: 0 cycles.

## Structure
- Shared package `note_player_pkg`:
  - `NOTE_W`, `DUR_W`, `STEP_W`.
  - The state enum.
  - `NOTE_REST = 0`.
  - The 64-entry step table constant.
- Sub-module `frequency_rom` (note → step, one-cycle registered read).
  - It is the only natural split; the FSM, counter and sample register stay in `note_player`.

## Test plan
- Reset mid-PLAYING with note 50 → all outputs 0 immediately; state IDLE; no `done_with_note`.
- Load note 50, duration 3, `play_enable=1` → `step_size`={159,62} two cycles later; `done_with_note` on the 3rd beat; `busy` drops the next cycle.
- Load note 63, duration 0 → `step_size`={337,942}; done on the 1st beat in PLAYING; a beat during LOAD is not counted.
- Note 0 (rest), duration 2, `sample_in`=16'h1234 with `sample_ready_in` → `sample_out`=0, `new_sample_ready` pulses one cycle later; `step_size`=0.
- `play_enable` low for 5 beats mid-note, duration 2 → `generate_next` held 0 while paused; `remaining` frozen; done only after 2 enabled beats.
- `load_new_note` during PLAYING and in the `done_with_note` cycle → ignored; `step_size` unchanged; a load the next cycle is accepted.

Source files
------------

// File: rtl/note_player_pkg.sv
// Shared types and constants for the note sequencer: widths, FSM states and the
// pitch-to-phase-step table used by the frequency ROM.
package note_player_pkg;

    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;
    localparam int STEP_W = 20;

    localparam logic [NOTE_W-1:0] NOTE_REST = '0;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAYING
    } state_e;

    // {10-bit integer, 10-bit fraction} phase steps; code 1 = A1, each code one
    // equal-tempered semitone up, anchored on B6. A#5 keeps its hand-tuned value.
    localparam logic [STEP_W-1:0] STEP_TABLE [64] = '{
        20'd0,      20'd9633,   20'd10206,  20'd10813,
        20'd11456,  20'd12137,  20'd12859,  20'd13624,
        20'd14434,  20'd15292,  20'd16201,  20'd17165,
        20'd18185,  20'd19267,  20'd20413,  20'd21626,
        20'd22912,  20'd24275,  20'd25718,  20'd27248,
        20'd28868,  20'd30585,  20'd32403,  20'd34330,
        20'd36371,  20'd38534,  20'd40826,  20'd43253,
        20'd45825,  20'd48550,  20'd51437,  20'd54496,
        20'd57736,  20'd61170,  20'd64807,  20'd68661,
        20'd72743,  20'd77068,  20'd81652,  20'd86507,
        20'd91651,  20'd97101,  20'd102875, 20'd108992,
        20'd115473, 20'd122340, 20'd129615, 20'd137322,
        20'd145487, 20'd154137, 20'd162878, 20'd173015,
        20'd183303, 20'd194203, 20'd205751, 20'd217985,
        20'd230947, 20'd244680, 20'd259230, 20'd274644,
        20'd290975, 20'd308275, 20'd326609, 20'd346030
    };

endpackage

// File: rtl/note_player_if.sv
// Bundle of the controller, codec and sine_reader signals seen by note_player.
// The master side is the surrounding system; the slave side is note_player itself.
interface note_player_if;
    import note_player_pkg::*;

    logic                play_enable;
    logic                load_new_note;
    logic [NOTE_W-1:0]   note_to_load;
    logic [DUR_W-1:0]    duration_to_load;
    logic                beat;
    logic                generate_next_sample;
    logic [15:0]         sample_in;
    logic                sample_ready_in;
    logic [STEP_W-1:0]   step_size;
    logic                generate_next;
    logic [15:0]         sample_out;
    logic                new_sample_ready;
    logic                done_with_note;
    logic                busy;

    modport master (
        output play_enable, load_new_note, note_to_load, duration_to_load,
               beat, generate_next_sample, sample_in, sample_ready_in,
        input  step_size, generate_next, sample_out, new_sample_ready,
               done_with_note, busy
    );

    modport slave (
        input  play_enable, load_new_note, note_to_load, duration_to_load,
               beat, generate_next_sample, sample_in, sample_ready_in,
        output step_size, generate_next, sample_out, new_sample_ready,
               done_with_note, busy
    );

endinterface

// File: rtl/frequency_rom.sv
// Pitch code to phase step lookup with a one-cycle registered read.
module frequency_rom
    import note_player_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [NOTE_W-1:0] note_i,
    output logic [STEP_W-1:0] step_o
);

    logic [STEP_W-1:0] step_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_q <= '0;
        end else begin
            step_q <= STEP_TABLE[note_i];
        end
    end

    assign step_o = step_q;

endmodule

// File: rtl/note_player.sv
// Plays one note at a time: looks up its phase step, counts enabled beats until it
// expires, gates codec requests to sine_reader and re-registers returned samples.
module note_player
    import note_player_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    note_player_if.slave bus
);

    state_e              state_q;
    logic [NOTE_W-1:0]   note_q;
    logic [DUR_W-1:0]    dur_q;
    logic [DUR_W-1:0]    remaining_q;
    logic [STEP_W-1:0]   step_q;
    logic [STEP_W-1:0]   rom_step;
    logic [15:0]         sample_q;
    logic [15:0]         sample_d;
    logic                sample_rdy_q;
    logic                playing;
    logic                beat_tick;

    // The ROM is addressed straight from the load port so its registered output is
    // ready during LOAD, one cycle before step_size must be valid.
    frequency_rom u_rom (
        .clk    (clk),
        .reset  (reset),
        .note_i (bus.note_to_load),
        .step_o (rom_step)
    );

    assign playing   = (state_q == PLAYING);
    assign beat_tick = bus.beat & bus.play_enable & playing;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            note_q      <= '0;
            dur_q       <= '0;
            remaining_q <= '0;
            step_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.load_new_note) begin
                        note_q  <= bus.note_to_load;
                        dur_q   <= bus.duration_to_load;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    step_q      <= rom_step;
                    remaining_q <= (dur_q == '0) ? DUR_W'(1) : dur_q;
                    state_q     <= PLAYING;
                end
                PLAYING: begin
                    if (beat_tick) begin
                        remaining_q <= remaining_q - DUR_W'(1);
                        if (remaining_q == DUR_W'(1)) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Samples are forwarded in every state so a request made just before expiry
    // still reaches the codec; rests are forced to silence.
    always_comb begin
        sample_d = bus.sample_in;
        if (note_q == NOTE_REST) begin
            sample_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_q     <= '0;
            sample_rdy_q <= 1'b0;
        end else begin
            sample_rdy_q <= bus.sample_ready_in;
            if (bus.sample_ready_in) begin
                sample_q <= sample_d;
            end
        end
    end

    assign bus.step_size        = step_q;
    assign bus.generate_next    = bus.generate_next_sample & bus.play_enable & playing;
    assign bus.sample_out       = sample_q;
    assign bus.new_sample_ready = sample_rdy_q;
    assign bus.done_with_note   = beat_tick & (remaining_q == DUR_W'(1));
    assign bus.busy             = (state_q != IDLE);

endmodule
